commit_trace_packer: RTL
========================

# commit_trace_packer

Synthesizable producer side of the commit trace path. It sits beside the commit stage and samples the commit ports, register write-back and exception every cycle. It packs each retired instruction and each trapped exception into a fixed-format record and streams the records out over a valid/ready port to an off-core trace sink. Commit cannot be back-pressured, so overflow is handled by dropping records and emitting one marker record that carries the drop count.

## Interface
Parameters:
- NrCommitPorts, 2, commit ports sampled per cycle
- Depth, 8, record buffer entries (power of two, ≥ NrCommitPorts+2)
- VLEN, 64, PC width
- XLEN, 64, data/cause/tval width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- trace_en_i  in  1  enable capture; buffer drains regardless
- commit_ack_i  in  NrCommitPorts  port i retires this cycle
- commit_pc_i  in  NrCommitPorts×VLEN  retiring PC
- commit_instr_i  in  NrCommitPorts×32  raw instruction word
- commit_rd_i  in  NrCommitPorts×5  destination register
- we_gpr_i / we_fpr_i  in  NrCommitPorts each  write-back to GPR / FPR
- wdata_i  in  NrCommitPorts×XLEN  write-back data
- priv_lvl_i  in  2  current privilege
- debug_mode_i  in  1  core in debug mode
- ex_valid_i  in  1  exception taken this cycle
- ex_cause_i / ex_tval_i  in  XLEN each  cause / tval
- trace_valid_o  out  1  record available
- trace_ready_i  in  1  sink accepts record
- trace_rec_o  out  trace_rec_t  head record
- drop_cnt_o  out  16  drops since last marker (debug visibility)

## Operation
- Per cycle, candidate records are built in this order:
  - one REC_INSTR per set commit_ack_i[i], port 0 first;
  - then one REC_EXC if ex_valid_i && !(debug_mode_i && ex_cause_i==BREAKPOINT(3)).
- need = number of candidates (0..NrCommitPorts+1). Nothing is built when trace_en_i=0.
- REC_INSTR fields:
  - pc, instr, rd, priv, debug;
  - rd_we = we_gpr_i[i]|we_fpr_i[i], rd_fpr = we_fpr_i[i];
  - data = wdata_i[i] if rd_we, else 0.
  - rd_we=0 whenever rd==0 and the write is not an FPR write.
- REC_EXC fields: pc = commit_pc_i[0], data = cause, tval = tval.
- free = Depth − occupancy, sampled at the start of the cycle. A same-cycle pop is not credited.
- Overflow handling:
  - If ovf_pending=1 and free≥1: enqueue REC_OVF with data = drop count (zero-extended) ahead of this cycle's records, clear ovf_pending, clear the counter, free−=1.
  - If need > free (after the marker): drop all `need` records. Enqueuing is all-or-nothing per cycle, never partial. Set ovf_pending and add need to the counter, saturating at 0xFFFF.
  - Otherwise enqueue all candidates in order.
- Output is the buffer head: trace_valid_o = occupancy≠0, and a pop occurs on valid&&ready.
- trace_rec_o must stay stable while valid && !ready.
- trace_en_i falling does not clear the buffer, ovf_pending or the counter.

## Timing
- Reset (rst_ni=0 at an edge): occupancy 0, ovf_pending 0, counter 0, trace_valid_o=0, drop_cnt_o=0. trace_rec_o is don't-care, driven as '0.
- Reset asserted mid-stream discards all buffered records on the same edge.
- Latency: a record committed in cycle N is visible on trace_valid_o in cycle N+1 if the buffer was empty.
- Throughput: 1 record/cycle out; up to NrCommitPorts+2 records/cycle in.
- Full with a pop in the same cycle: the pop still happens, but the free count ignores it. Records are dropped if need > 0.
- Empty with need>0 and ready=1: no combinational bypass; output appears next cycle.
- Pointers wrap modulo Depth; occupancy is a log2(Depth)+1 bit counter.

## Structure
- trace_pkg holds:
  - rec_type_e {REC_INSTR, REC_EXC, REC_OVF} (2 bits);
  - trace_rec_t {type, pc, instr, rd, rd_we, rd_fpr, priv, debug, data, tval};
  - the BREAKPOINT cause constant, reused from the riscv package.
- Sub-module commit_trace_fifo: multi-push (up to NrCommitPorts+2 per cycle, in order), single-pop circular buffer. It exposes free count, and push_cnt/push_data vector inputs.
- The top level contains only record formation, drop and marker control, and the counter.

## Test plan
- Single commit: ack=01, pc=0x8000_0000, instr=0x00500093, rd=1, we_gpr=1, wdata=5, ready=1.
  - Expect REC_INSTR next cycle with rd_we=1 and data=5, then valid drops.
- Dual commit plus exception (cause=2, tval=0xdead) in one cycle.
  - Expect 3 records in order: port0, port1, REC_EXC. pc of REC_EXC = port0 pc.
- Backpressure: ready=0, 10 single commits with Depth=8.
  - Expect 8 records held stable, the last 2 dropped, drop_cnt_o=2.
  - Raise ready: 8 records, then REC_OVF data=2, then new traffic.
- Saturation: hold ready=0 for 70000 commit cycles.
  - Expect drop_cnt_o=0xFFFF with no wrap; REC_OVF data=0xFFFF after draining.
- Debug breakpoint: ex_valid=1, cause=3, debug_mode=1 → no REC_EXC.
  - Same with debug_mode=0 → REC_EXC emitted.
- Reset mid-stream: 5 buffered records, rst_ni=0 for one cycle.
  - Expect valid=0, drop_cnt_o=0, no REC_OVF afterward.

Source files
------------

// File: rtl/commit_trace_packer_pkg.sv
// Shared types and constants for the commit trace path: record layout,
// record type encoding, the debug breakpoint cause and a saturating adder.
package commit_trace_packer_pkg;

    localparam int unsigned TraceVlen = 64;
    localparam int unsigned TraceXlen = 64;

    // Breakpoint exception cause, same value as the RISC-V privileged encoding
    localparam logic [TraceXlen-1:0] BREAKPOINT = 64'd3;

    typedef enum logic [1:0] {
        REC_INSTR = 2'd0,
        REC_EXC   = 2'd1,
        REC_OVF   = 2'd2
    } rec_type_e;

    typedef struct packed {
        rec_type_e              rec_type;
        logic [TraceVlen-1:0]   pc;
        logic [31:0]            instr;
        logic [4:0]             rd;
        logic                   rd_we;
        logic                   rd_fpr;
        logic [1:0]             priv;
        logic                   debug;
        logic [TraceXlen-1:0]   data;
        logic [TraceXlen-1:0]   tval;
    } trace_rec_t;

    // 16-bit add that clamps at all-ones instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Circular record buffer: up to MaxPush in-order writes per cycle, one read
// per cycle. The caller guarantees push_cnt_i never exceeds free_o.
module commit_trace_fifo
    import commit_trace_packer_pkg::*;
#(
    parameter int unsigned Depth   = 8,
    parameter int unsigned MaxPush = 4,
    localparam int unsigned PtrW   = $clog2(Depth),
    localparam int unsigned OccW   = PtrW + 1,
    localparam int unsigned CntW   = $clog2(MaxPush + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [CntW-1:0]                push_cnt_i,
    input  trace_rec_t [MaxPush-1:0]       push_data_i,
    input  logic                           pop_i,
    output logic [OccW-1:0]                free_o,
    output logic                           valid_o,
    output trace_rec_t                     head_o
);

    trace_rec_t         mem_r [Depth];
    logic [PtrW-1:0]    wr_ptr_r;
    logic [PtrW-1:0]    rd_ptr_r;
    logic [OccW-1:0]    occ_r;
    logic [OccW-1:0]    occ_s;
    logic               valid_r;
    logic               pop_s;

    // A read request only counts when a record is actually held
    assign pop_s  = pop_i && valid_r;
    assign free_o = OccW'(Depth) - occ_r;

    // Next occupancy from this cycle's writes and read
    always_comb begin
        occ_s = occ_r + OccW'(push_cnt_i) - OccW'(pop_s);
    end

    // Pointer, occupancy and valid-flag registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
            valid_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PtrW'(push_cnt_i);
            rd_ptr_r <= rd_ptr_r + PtrW'(pop_s);
            occ_r    <= occ_s;
            valid_r  <= (occ_s != '0);
        end
    end

    // Storage array: write the first push_cnt_i entries at consecutive slots
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < MaxPush; k++) begin
            if (rst_ni && (CntW'(k) < push_cnt_i)) begin
                mem_r[wr_ptr_r + PtrW'(k)] <= push_data_i[k];
            end
        end
    end

    // Head record; zero when nothing is held so the output is defined after reset
    always_comb begin
        if (valid_r) begin
            head_o = mem_r[rd_ptr_r];
        end else begin
            head_o = '0;
        end
    end

    assign valid_o = valid_r;

endmodule

// File: rtl/commit_trace_packer.sv
// Commit trace producer: turns retiring instructions and taken exceptions into
// fixed-format records, buffers them and streams them out on valid/ready.
// Commit cannot stall, so a cycle whose records do not fit is dropped whole
// and a later overflow marker reports how many records were lost.
module commit_trace_packer
    import commit_trace_packer_pkg::*;
#(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned Depth         = 8,
    parameter int unsigned VLEN          = TraceVlen,
    parameter int unsigned XLEN          = TraceXlen
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                trace_en_i,
    input  logic [NrCommitPorts-1:0]            commit_ack_i,
    input  logic [NrCommitPorts-1:0][VLEN-1:0]  commit_pc_i,
    input  logic [NrCommitPorts-1:0][31:0]      commit_instr_i,
    input  logic [NrCommitPorts-1:0][4:0]       commit_rd_i,
    input  logic [NrCommitPorts-1:0]            we_gpr_i,
    input  logic [NrCommitPorts-1:0]            we_fpr_i,
    input  logic [NrCommitPorts-1:0][XLEN-1:0]  wdata_i,
    input  logic [1:0]                          priv_lvl_i,
    input  logic                                debug_mode_i,
    input  logic                                ex_valid_i,
    input  logic [XLEN-1:0]                     ex_cause_i,
    input  logic [XLEN-1:0]                     ex_tval_i,
    output logic                                trace_valid_o,
    input  logic                                trace_ready_i,
    output trace_rec_t                          trace_rec_o,
    output logic [15:0]                         drop_cnt_o
);

    localparam int unsigned MaxPush = NrCommitPorts + 2;
    localparam int unsigned PtrW    = $clog2(Depth);
    localparam int unsigned OccW    = PtrW + 1;
    localparam int unsigned CntW    = $clog2(MaxPush + 1);
    localparam int unsigned IdxW    = $clog2(MaxPush);
    localparam int unsigned CmpW    = OccW + CntW;

    trace_rec_t [MaxPush-1:0]   push_data_s;
    trace_rec_t                 rec_s;
    logic [CntW-1:0]            idx_s;
    logic [CntW-1:0]            need_s;
    logic [CntW-1:0]            push_cnt_s;
    logic [OccW-1:0]            free_s;
    logic [OccW-1:0]            room_s;
    logic                       marker_s;
    logic                       drop_s;
    logic                       exc_s;
    logic                       ovf_pending_r;
    logic                       ovf_pending_s;
    logic [15:0]                drop_cnt_r;
    logic [15:0]                drop_cnt_s;
    logic [15:0]                cnt_base_s;

    // Exceptions are traced except breakpoints taken while already in debug mode
    assign exc_s = ex_valid_i && !(debug_mode_i && (ex_cause_i == XLEN'(BREAKPOINT)));

    // Record formation: optional marker first, then ports in order, then exception
    always_comb begin
        push_data_s = '0;
        rec_s       = '0;
        idx_s       = '0;
        need_s      = '0;
        marker_s    = ovf_pending_r && (free_s != '0);
        room_s      = free_s - OccW'(marker_s);
        if (marker_s) begin
            rec_s                       = '0;
            rec_s.rec_type              = REC_OVF;
            rec_s.data                  = TraceXlen'(drop_cnt_r);
            push_data_s[0]              = rec_s;
            idx_s                       = CntW'(1);
        end else begin
            idx_s                       = '0;
        end
        for (int i = 0; i < NrCommitPorts; i++) begin
            if (trace_en_i && commit_ack_i[i]) begin
                rec_s          = '0;
                rec_s.rec_type = REC_INSTR;
                rec_s.pc       = TraceVlen'(commit_pc_i[i]);
                rec_s.instr    = commit_instr_i[i];
                rec_s.rd       = commit_rd_i[i];
                rec_s.rd_we    = we_fpr_i[i] || (we_gpr_i[i] && (commit_rd_i[i] != 5'd0));
                rec_s.rd_fpr   = we_fpr_i[i];
                rec_s.priv     = priv_lvl_i;
                rec_s.debug    = debug_mode_i;
                if (rec_s.rd_we) begin
                    rec_s.data = TraceXlen'(wdata_i[i]);
                end else begin
                    rec_s.data = '0;
                end
                push_data_s[idx_s[IdxW-1:0]] = rec_s;
                idx_s  = idx_s + CntW'(1);
                need_s = need_s + CntW'(1);
            end else begin
                need_s = need_s;
            end
        end
        if (trace_en_i && exc_s) begin
            rec_s          = '0;
            rec_s.rec_type = REC_EXC;
            rec_s.pc       = TraceVlen'(commit_pc_i[0]);
            rec_s.data     = TraceXlen'(ex_cause_i);
            rec_s.tval     = TraceXlen'(ex_tval_i);
            push_data_s[idx_s[IdxW-1:0]] = rec_s;
            idx_s  = idx_s + CntW'(1);
            need_s = need_s + CntW'(1);
        end else begin
            need_s = need_s;
        end
    end

    // Drop decision and next marker/counter state; a cycle is kept whole or dropped whole
    always_comb begin
        drop_s = (CmpW'(need_s) > CmpW'(room_s));
        if (marker_s) begin
            cnt_base_s = 16'd0;
        end else begin
            cnt_base_s = drop_cnt_r;
        end
        if (drop_s) begin
            push_cnt_s    = CntW'(marker_s);
            drop_cnt_s    = sat_add16(cnt_base_s, 16'(need_s));
            ovf_pending_s = 1'b1;
        end else begin
            push_cnt_s    = idx_s;
            drop_cnt_s    = cnt_base_s;
            ovf_pending_s = ovf_pending_r && !marker_s;
        end
    end

    // Overflow-pending flag and drop counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_pending_r <= 1'b0;
            drop_cnt_r    <= 16'd0;
        end else begin
            ovf_pending_r <= ovf_pending_s;
            drop_cnt_r    <= drop_cnt_s;
        end
    end

    commit_trace_fifo #(
        .Depth      (Depth),
        .MaxPush    (MaxPush)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_cnt_i (push_cnt_s),
        .push_data_i(push_data_s),
        .pop_i      (trace_ready_i),
        .free_o     (free_s),
        .valid_o    (trace_valid_o),
        .head_o     (trace_rec_o)
    );

    assign drop_cnt_o = drop_cnt_r;

endmodule
